// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR result packer:
//   - ser_state_e : serializer FSM state encoding (HDR only exists when the
//                   sync header is compiled in)
//   - HDR_BYTE    : sync byte sent ahead of every sample in framed mode
//   - sat_max/min : signed saturation limits for a given output width
// Optional feature macro: FIR_RESULT_PACKER_FRAME_EN
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef FIR_RESULT_PACKER_FRAME_EN
        ST_HDR  = 2'd1,
`endif
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } ser_state_e;

    // Largest value representable in a signed field of 'width' bits.
    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of 'width' bits.
    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered read port. A pop (rd_en while not
// empty) loads the head entry into rd_data at the clock edge; rd_data then
// holds that value until the next pop.
// Parameters: WIDTH (entry width), DEPTH (power of two, >= 2)
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (pointers, count, rd_data)
//   wr_en    : push wr_data (ignored while full)
//   wr_data  : entry to push
//   rd_en    : pop head into rd_data (ignored while empty)
//   rd_data  : registered head entry from the last pop
//   full     : count == DEPTH
//   empty    : count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            if (do_wr && !do_rd) begin
                count <= count + CNT_ONE;
            end else if (do_rd && !do_wr) begin
                count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_result_packer.sv
// ---------------------------------------------------------------------------
// fir_result_packer
// Takes signed FIR results, rounds/shifts/saturates them to OUT_WIDTH bits,
// buffers them in a FIFO and serializes each sample LSB-first as bytes for a
// UART transmitter. Stops accepting after SAMPLE_LIMIT samples (o_comp) while
// still draining what is buffered.
// Optional feature macro: FIR_RESULT_PACKER_FRAME_EN -- when defined, every
// sample is preceded by the sync byte 0xA5 (HDR state).
// Parameters: IN_WIDTH, OUT_WIDTH (multiple of 8), SHIFT (>= 1),
//             FIFO_DEPTH (power of two, >= 2), SAMPLE_LIMIT
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_wr_en    : sample write strobe from the FIR stage
//   i_data     : signed FIR result
//   o_full     : FIFO holds FIFO_DEPTH entries
//   o_comp     : capture complete, sticky until reset
//   o_overflow : sticky, a write was dropped because the FIFO was full
//   o_tx_data  : byte to the UART
//   o_tx_valid : o_tx_data is valid
//   i_tx_ready : UART accepts the byte this cycle
//
// Serializer states:
//   state   | meaning
//   IDLE    | no byte pending; pops the next sample when the UART is ready
//   HDR     | sending sync byte 0xA5 (framed build only)
//   LO      | sending all but the last data byte of the sample
//   HI      | sending the last (most significant) data byte
// ---------------------------------------------------------------------------
module fir_result_packer
    import fir_pkg::*;
#(
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int SHIFT        = 15,
    parameter int FIFO_DEPTH   = 16,
    parameter int SAMPLE_LIMIT = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [IN_WIDTH-1:0] i_data,
    output logic                o_full,
    output logic                o_comp,
    output logic                o_overflow,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready
);

    localparam int NBYTES = OUT_WIDTH / 8;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(SAMPLE_LIMIT + 1);

    localparam logic signed [63:0]       SAT_HI   = sat_max(OUT_WIDTH);
    localparam logic signed [63:0]       SAT_LO   = sat_min(OUT_WIDTH);
    localparam logic signed [IN_WIDTH:0] RND      = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SAMPLE_LIMIT - 1);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic [BIDX_W-1:0]        BIDX_ONE = BIDX_W'(1);
    localparam logic [BIDX_W-1:0]        BIDX_END = BIDX_W'(NBYTES - 1);
    localparam logic [BIDX_W-1:0]        BIDX_PRE = BIDX_W'(NBYTES - 2);

    // ---------------- scaling: round, shift, saturate ----------------
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] rnd_sum;
    logic signed [IN_WIDTH:0] shifted;
    logic signed [63:0]       wide;
    logic [OUT_WIDTH-1:0]     scaled;

    always_comb begin
        // One extra sign bit keeps the rounding add from overflowing.
        ext     = {i_data[IN_WIDTH-1], i_data};
        rnd_sum = ext + RND;
        shifted = rnd_sum >>> SHIFT;
        wide    = {{(63 - IN_WIDTH){shifted[IN_WIDTH]}}, shifted};
        if (wide > SAT_HI) begin
            scaled = SAT_HI[OUT_WIDTH-1:0];
        end else if (wide < SAT_LO) begin
            scaled = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            scaled = wide[OUT_WIDTH-1:0];
        end
    end

    // ---------------- write acceptance and status flags ----------------
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [OUT_WIDTH-1:0] fifo_rd_data;
    logic                 wr_accept;
    logic                 wr_drop;
    logic [CNT_W-1:0]     sample_cnt;
    logic                 comp_q;
    logic                 ovf_q;

    // Full is the registered FIFO state, so a write while full is dropped
    // even when the serializer pops in the same cycle.
    assign wr_accept = i_wr_en && !fifo_full && !comp_q;
    assign wr_drop   = i_wr_en &&  fifo_full && !comp_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sample_cnt <= '0;
            comp_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr_accept) begin
                sample_cnt <= sample_cnt + CNT_ONE;
                if (sample_cnt == CNT_LAST) begin
                    comp_q <= 1'b1;
                end
            end
            if (wr_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign o_full     = fifo_full;
    assign o_comp     = comp_q;
    assign o_overflow = ovf_q;

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_accept),
        .wr_data (scaled),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------- serializer FSM ----------------
    ser_state_e           state_q;
    ser_state_e           state_d;
    logic [BIDX_W-1:0]    bidx_q;
    logic [BIDX_W-1:0]    bidx_d;
    logic [OUT_WIDTH-1:0] sreg_q;
    logic [OUT_WIDTH-1:0] sreg_d;
    logic [OUT_WIDTH-1:0] tx_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            bidx_q  <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
            sreg_q  <= sreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bidx_d     = bidx_q;
        sreg_d     = sreg_q;
        fifo_pop   = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        // The popped word lands in the FIFO's output register; the first data
        // byte comes from there and the remainder from the shift register.
        tx_word    = (bidx_q == '0) ? fifo_rd_data : sreg_q;

        case (state_q)
            ST_IDLE: begin
                // Pull a sample only when the UART can take it, so the FIFO
                // exposes its full depth as back-pressure while stalled.
                if (!fifo_empty && i_tx_ready) begin
                    fifo_pop = 1'b1;
                    bidx_d   = '0;
`ifdef FIR_RESULT_PACKER_FRAME_EN
                    state_d  = ST_HDR;
`else
                    state_d  = ST_LO;
`endif
                end
            end
`ifdef FIR_RESULT_PACKER_FRAME_EN
            ST_HDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = HDR_BYTE;
                if (i_tx_ready) begin
                    state_d = ST_LO;
                end
            end
`endif
            ST_LO: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tx_word[7:0];
                if (i_tx_ready) begin
                    sreg_d = tx_word >> 8;
                    bidx_d = bidx_q + BIDX_ONE;
                    if (bidx_q == BIDX_END) begin
                        state_d = ST_IDLE;
                    end else if (bidx_q == BIDX_PRE) begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tx_word[7:0];
                if (i_tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_result_packer.sv
// ---------------------------------------------------------------------------
// tb_fir_result_packer
// Self-checking bench for fir_result_packer. Expected bytes come from a
// queue filled by an arithmetic reference of the scaling rule (or fixed
// constants for the directed cases); a monitor drains it on each transfer.
// Optional feature macro: FIR_RESULT_PACKER_FRAME_EN
// ---------------------------------------------------------------------------
module tb_fir_result_packer;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 16;
    localparam int LIMIT = 64;
    localparam int NB    = OUT_W / 8;
`ifdef FIR_RESULT_PACKER_FRAME_EN
    localparam bit FRAME = 1'b1;
    localparam int BPS   = NB + 1;
`else
    localparam bit FRAME = 1'b0;
    localparam int BPS   = NB;
`endif

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            wr_en    = 1'b0;
    logic [IN_W-1:0] data     = '0;
    logic            tx_ready = 1'b0;
    logic            full;
    logic            comp;
    logic            ovf;
    logic [7:0]      tx_data;
    logic            tx_valid;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         ready_mode   = 0;   // 0 manual, 1 random, 2 toggle
    int         acc_cnt      = 0;
    int         bytes_done   = 0;
    logic [7:0] exp_q[$];
    bit         prev_stall   = 1'b0;
    logic [7:0] prev_byte    = 8'h00;

    always #5 clk = ~clk;

    fir_result_packer #(
        .IN_WIDTH     (IN_W),
        .OUT_WIDTH    (OUT_W),
        .SHIFT        (SHIFT),
        .FIFO_DEPTH   (DEPTH),
        .SAMPLE_LIMIT (LIMIT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_data     (data),
        .o_full     (full),
        .o_comp     (comp),
        .o_overflow (ovf),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round to nearest (half up), floor-shift, clamp: plain integer arithmetic.
    function automatic longint scale_ref(input logic [IN_W-1:0] d);
        longint v, num, div, q, hi, lo;
        v   = longint'($signed(d));
        div = longint'(1) << SHIFT;
        num = v + (div / 2);
        q   = num / div;
        if ((num % div) != 0 && num < 0) q = q - 1;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    function automatic logic [IN_W-1:0] rand_data();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0: return r;
            1: return {{12{r[19]}}, r[19:0]};
            2: begin
                r = (32'($urandom_range(0, 2047)) << 15) + 32'h4000 + 32'($urandom_range(0, 2)) - 32'd1;
                return r[0] ? -r : r;
            end
            default: begin
                r = 32'h3FFF_8000 + 32'($urandom_range(0, 65535)) - 32'd32768;
                return r[0] ? -r : r;
            end
        endcase
    endfunction

    function automatic int outstanding();
        return acc_cnt - bytes_done / BPS;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [IN_W-1:0] d);
        wr_en = 1'b1;
        data  = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_model(input logic [IN_W-1:0] d, input bit accept);
        longint q;
        if (accept) begin
            acc_cnt++;
            q = scale_ref(d);
            if (FRAME) exp_q.push_back(8'hA5);
            for (int k = 0; k < NB; k++) exp_q.push_back(8'((q >> (8 * k)) & 255));
        end
        drive_write(d);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        exp_q.delete();
        acc_cnt    = 0;
        bytes_done = 0;
        tick();
        check_eq("rst_full", full, 0);
        check_eq("rst_comp", comp, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_valid", tx_valid, 0);
        check_eq("rst_data", tx_data, 0);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        check_eq({tag, "_idle"}, tx_valid, 0);
    endtask

    // Ready driver for the random/toggle modes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) tx_ready = ~tx_ready;
        end
    end

    // Byte monitor: scoreboard and hold-while-stalled check.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", tx_valid, 1);
                check_eq("hold_data", tx_data, prev_byte);
            end
            if (tx_valid && tx_ready) begin
                check_eq("byte_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("tx_byte", tx_data, exp_q.pop_front());
                bytes_done++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    logic [IN_W-1:0] dir_data [6] = '{32'h0000_8000, 32'h0000_4000, 32'h0000_3FFF,
                                      32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    logic [15:0]     dir_exp  [6] = '{16'h0001, 16'h0001, 16'h0000,
                                      16'h7FFF, 16'h8000, 16'h0002};

    initial begin
        logic [15:0] w;
        tick();
        reset_dut();

        // Directed values with known packed results.
        ready_mode = 0;
        tx_ready   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) ready_mode = 2;
            w = dir_exp[i];
            acc_cnt++;
            if (FRAME) exp_q.push_back(8'hA5);
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            drive_write(dir_data[i]);
            wait_drain("directed");
        end

        // First byte two cycles after the accepting cycle.
        ready_mode = 0;
        tx_ready   = 1'b1;
        repeat (2) tick();
        write_model(32'h0000_8000, 1'b1);
        @(negedge clk);
        check_eq("lat_n1_valid", tx_valid, 0);
        @(negedge clk);
        check_eq("lat_n2_valid", tx_valid, 1);
        wait_drain("latency");

        // Reset after the first byte of a sample has gone out.
        tx_ready = 1'b0;
        write_model(32'h0001_0000, 1'b1);
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10 && !tx_valid; i++) @(negedge clk);
        check_eq("mid_wait_valid", tx_valid, 1);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        tick();
        check_eq("mid_stalled", tx_valid, 1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        reset_dut();
        tick();
        check_eq("mid_after_rst_valid", tx_valid, 0);

        // Random traffic with random back-pressure, kept below FIFO capacity.
        ready_mode = 1;
        for (int i = 0; i < 120; i++) begin
            if (outstanding() < DEPTH && $urandom_range(0, 2) != 0 && acc_cnt < 40)
                write_model(rand_data(), 1'b1);
            else
                tick();
        end
        wait_drain("random");

        // Fill, overflow, and a write dropped while a pop happens.
        ready_mode = 0;
        tx_ready   = 1'b0;
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            write_model(rand_data(), 1'b1);
            check_eq($sformatf("full_after_w%0d", i + 1), full, (i == DEPTH - 1) ? 1 : 0);
        end
        check_eq("ovf_before_drop", ovf, 0);
        write_model(rand_data(), 1'b0);
        check_eq("full_after_drop", full, 1);
        check_eq("ovf_after_drop", ovf, 1);
        tx_ready = 1'b1;
        write_model(rand_data(), 1'b0);
        tx_ready = 1'b0;
        check_eq("full_after_pop_drop", full, 0);
        check_eq("ovf_sticky", ovf, 1);
        ready_mode = 1;
        wait_drain("overflow");
        check_eq("overflow_byte_count", bytes_done, DEPTH * BPS);

        // Capture completion.
        reset_dut();
        ready_mode = 1;
        for (int it = 0; it < 20000 && acc_cnt < LIMIT; it++) begin
            if (outstanding() < DEPTH) begin
                write_model(rand_data(), 1'b1);
                check_eq($sformatf("comp_after_w%0d", acc_cnt), comp, (acc_cnt >= LIMIT) ? 1 : 0);
            end else begin
                tick();
            end
        end
        ready_mode = 0;
        tx_ready   = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) write_model(rand_data(), 1'b0);
        check_eq("comp_sticky", comp, 1);
        check_eq("comp_no_ovf", ovf, 0);
        check_eq("comp_not_full", full, 0);
        ready_mode = 1;
        wait_drain("comp");
        check_eq("comp_byte_count", bytes_done, LIMIT * BPS);
        repeat (20) tick();
        check_eq("comp_no_extra", bytes_done, LIMIT * BPS);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
